// File: rtl/pkt_queue_sched_if.sv
// Bundled tag strobe, per-queue input streams and merged output stream.
// The scheduler uses the slave modport; the driving side uses master.
interface pkt_queue_sched_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES         = 4
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int NQ = C_NUM_QUEUES;

  logic [NQ-1:0]    tag_in;
  logic             tag_valid;
  logic             tag_ready;

  logic [NQ*DW-1:0] s_axis_tdata;
  logic [NQ*UW-1:0] s_axis_tuser;
  logic [NQ*KW-1:0] s_axis_tkeep;
  logic [NQ-1:0]    s_axis_tlast;
  logic [NQ-1:0]    s_axis_tvalid;
  logic [NQ-1:0]    s_axis_tready;

  logic [DW-1:0]    m_axis_tdata;
  logic [UW-1:0]    m_axis_tuser;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  modport master (
    output tag_in, tag_valid, s_axis_tdata, s_axis_tuser, s_axis_tkeep,
           s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  tag_ready, s_axis_tready, m_axis_tdata, m_axis_tuser,
           m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    input  tag_in, tag_valid, s_axis_tdata, s_axis_tuser, s_axis_tkeep,
           s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output tag_ready, s_axis_tready, m_axis_tdata, m_axis_tuser,
           m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/pkt_queue_sched.sv
// Merges per-queue packet streams into one AXIS stream in PHV tag order, one whole packet per tag.
// Define QSCHED_STATS_EN to enable the per-queue completed-packet counters.
module pkt_queue_sched #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES         = 4,
  parameter int TAG_FIFO_DEPTH       = 16,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  pkt_queue_sched_if.slave                  bus,
  output logic [C_CNT_WIDTH-1:0]            err_tag_cnt,
  output logic [C_NUM_QUEUES*C_CNT_WIDTH-1:0] pkt_cnt
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int NQ = C_NUM_QUEUES;
  localparam int CW = C_CNT_WIDTH;
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int AW = $clog2(TAG_FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] cur_q_q, cur_q_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [NQ-1:0] fifo_mem_q [TAG_FIFO_DEPTH];
  logic [CW-1:0] err_cnt_q;

  logic          full, empty, tag_acc, push, pop, err_inc, sending, xfer_last;
  logic [NQ-1:0] head;
  logic [QW-1:0] head_idx;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign bus.tag_ready = aresetn & ~full;
  assign tag_acc = bus.tag_valid & bus.tag_ready;
  assign push    = tag_acc & $onehot(bus.tag_in);
  assign err_inc = tag_acc & ~$onehot(bus.tag_in);

  assign head = fifo_mem_q[rd_ptr_q[AW-1:0]];
  always_comb begin
    head_idx = '0;
    for (int i = 0; i < NQ; i++)
      if (head[i]) head_idx = head_idx | QW'(i);
  end

  always_ff @(posedge axis_clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.tag_in;
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
      state_q   <= IDLE;
      cur_q_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (err_inc && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_ONE;
      state_q <= state_d;
      cur_q_q <= cur_q_d;
    end
  end

  assign err_tag_cnt = err_cnt_q;

  // Output path is a pure mux of the selected queue while in SEND.
  assign sending           = aresetn && (state_q == SEND);
  assign bus.m_axis_tdata  = bus.s_axis_tdata[int'(cur_q_q)*DW +: DW];
  assign bus.m_axis_tuser  = bus.s_axis_tuser[int'(cur_q_q)*UW +: UW];
  assign bus.m_axis_tkeep  = bus.s_axis_tkeep[int'(cur_q_q)*KW +: KW];
  assign bus.m_axis_tlast  = bus.s_axis_tlast[cur_q_q];
  assign bus.m_axis_tvalid = sending & bus.s_axis_tvalid[cur_q_q];
  assign xfer_last = bus.m_axis_tvalid & bus.m_axis_tready & bus.m_axis_tlast;

  always_comb begin
    bus.s_axis_tready = '0;
    if (sending) bus.s_axis_tready[cur_q_q] = bus.m_axis_tready;
  end

  always_comb begin
    state_d = state_q;
    cur_q_d = cur_q_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        cur_q_d = head_idx;
        state_d = SEND;
      end
      SEND: if (xfer_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef QSCHED_STATS_EN
  logic [NQ-1:0][CW-1:0] pkt_cnt_q;
  for (genvar g = 0; g < NQ; g++) begin : g_cnt
    always_ff @(posedge axis_clk) begin
      if (!aresetn)                             pkt_cnt_q[g] <= '0;
      else if (xfer_last && cur_q_q == QW'(g)) pkt_cnt_q[g] <= pkt_cnt_q[g] + CNT_ONE;
    end
  end
  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif
endmodule
